// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: default base addresses,
// MMIO register offsets, TIMER_STAT bit index and the address-decode select type.
package dmem_responder_pkg;

    localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h1001_0000;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [3:0] OFF_GPIO_OUT    = 4'h0;
    localparam logic [3:0] OFF_TIMER_COUNT = 4'h4;
    localparam logic [3:0] OFF_TIMER_CMP   = 4'h8;
    localparam logic [3:0] OFF_TIMER_STAT  = 4'hC;

    localparam int TIMER_STAT_MATCH_BIT = 0;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_RAM    = 3'd1,
        SEL_GPIO   = 3'd2,
        SEL_TCOUNT = 3'd3,
        SEL_TCMP   = 3'd4,
        SEL_TSTAT  = 3'd5
    } sel_e;

    // Map a word offset inside the 16-byte MMIO window to its register.
    function automatic sel_e mmio_sel(input logic [3:0] off);
        sel_e sel;
        case (off)
            OFF_GPIO_OUT:    sel = SEL_GPIO;
            OFF_TIMER_COUNT: sel = SEL_TCOUNT;
            OFF_TIMER_CMP:   sel = SEL_TCMP;
            OFF_TIMER_STAT:  sel = SEL_TSTAT;
            default:         sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running 32-bit timer with a compare register and a sticky match flag;
// a match at the same edge as a clear request keeps the flag set.
module dmem_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmp_we,
    input  logic [31:0] cmp_wdata,
    input  logic        stat_clr,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic        match
);

    logic [31:0] count_r;
    logic [31:0] cmp_r;
    logic        match_r;

    // Counter, compare register and match flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 32'h0000_0000;
            cmp_r   <= 32'hFFFF_FFFF;
            match_r <= 1'b0;
        end else begin
            count_r <= count_r + 32'd1;
            if (cmp_we) begin
                cmp_r <= cmp_wdata;
            end
            if (count_r == cmp_r) begin
                match_r <= 1'b1;
            end else if (stat_clr) begin
                match_r <= 1'b0;
            end
        end
    end

    assign count = count_r;
    assign cmp   = cmp_r;
    assign match = match_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a small MMIO block (GPIO, optional timer).
// Define DMEM_TIMER_EN to build the timer; without it the timer registers read 0.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DMEM_addr,
    input  logic [31:0] DMEM_wdata,
    input  logic        DMEM_we,
    input  logic [31:0] fetch_DMEM_addr,
    output logic [31:0] DMEM_rdata,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        addr_err,
    output logic        fetch_err
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

    logic [31:0] mem [DEPTH];

    logic [31:0] ram_off_s;
    logic [31:0] mmio_off_s;
    logic        ram_hit_s;
    logic        mmio_hit_s;
    logic        aligned_s;
    logic [AW-1:0] ram_idx_s;
    sel_e        sel_s;
    logic        err_s;
    logic [31:0] rd_data_s;
    logic        ram_we_s;
    logic        gpio_we_s;

    logic [31:0] timer_count_s;
    logic [31:0] timer_cmp_s;
    logic        match_s;

    logic [31:0] rdata_r;
    logic [31:0] gpio_r;
    logic [31:0] addr_r;
    logic        addr_err_r;
    logic        fetch_err_r;

    // Offsets are taken by subtraction so a single unsigned compare bounds each window.
    assign ram_off_s  = DMEM_addr - RAM_BASE;
    assign mmio_off_s = DMEM_addr - MMIO_BASE;
    assign ram_hit_s  = ({1'b0, ram_off_s} < RAM_BYTES);
    assign mmio_hit_s = (mmio_off_s[31:4] == 28'd0);
    assign aligned_s  = (DMEM_addr[1:0] == 2'b00);
    assign ram_idx_s  = ram_off_s[AW+1:2];

    // Address decode; anything unaligned or outside both windows is an error.
    always_comb begin
        sel_s = SEL_NONE;
        if (!aligned_s) begin
            sel_s = SEL_NONE;
        end else if (ram_hit_s) begin
            sel_s = SEL_RAM;
        end else if (mmio_hit_s) begin
            sel_s = mmio_sel(mmio_off_s[3:0]);
        end else begin
            sel_s = SEL_NONE;
        end
    end

    assign err_s     = (sel_s == SEL_NONE);
    assign ram_we_s  = DMEM_we && (sel_s == SEL_RAM);
    assign gpio_we_s = DMEM_we && (sel_s == SEL_GPIO);

`ifdef DMEM_TIMER_EN
    logic cmp_we_s;
    logic stat_clr_s;

    assign cmp_we_s   = DMEM_we && (sel_s == SEL_TCMP);
    assign stat_clr_s = DMEM_we && (sel_s == SEL_TSTAT) && DMEM_wdata[TIMER_STAT_MATCH_BIT];

    dmem_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .cmp_we    (cmp_we_s),
        .cmp_wdata (DMEM_wdata),
        .stat_clr  (stat_clr_s),
        .count     (timer_count_s),
        .cmp       (timer_cmp_s),
        .match     (match_s)
    );
`else
    assign timer_count_s = 32'h0000_0000;
    assign timer_cmp_s   = 32'h0000_0000;
    assign match_s       = 1'b0;
`endif

    // Read-data select for the address presented this cycle.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (sel_s)
            SEL_RAM:    rd_data_s = mem[ram_idx_s];
            SEL_GPIO:   rd_data_s = gpio_r;
            SEL_TCOUNT: rd_data_s = timer_count_s;
            SEL_TCMP:   rd_data_s = timer_cmp_s;
            SEL_TSTAT:  rd_data_s = {31'd0, match_s};
            default:    rd_data_s = 32'h0000_0000;
        endcase
    end

    // RAM array has no reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (ram_we_s && !reset) begin
            mem[ram_idx_s] <= DMEM_wdata;
        end
    end

    // Read register, GPIO, sampled address and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r     <= 32'h0000_0000;
            gpio_r      <= 32'h0000_0000;
            addr_r      <= 32'h0000_0000;
            addr_err_r  <= 1'b0;
            fetch_err_r <= 1'b0;
        end else begin
            rdata_r     <= rd_data_s;
            addr_r      <= DMEM_addr;
            addr_err_r  <= addr_err_r | err_s;
            fetch_err_r <= fetch_err_r | (fetch_DMEM_addr != addr_r);
            if (gpio_we_s) begin
                gpio_r <= DMEM_wdata;
            end
        end
    end

    assign DMEM_rdata = rdata_r;
    assign gpio_out   = gpio_r;
    assign timer_irq  = match_s;
    assign addr_err   = addr_err_r;
    assign fetch_err  = fetch_err_r;

endmodule
